// File: rtl/inst_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: immediate-format codes
// (same encoding as the decoder's ImmType), base opcodes and a range helper.
package inst_encoder_pkg;

   typedef enum logic [2:0] {
      IMM_R = 3'd0,
      IMM_I = 3'd1,
      IMM_S = 3'd2,
      IMM_B = 3'd3,
      IMM_U = 3'd4,
      IMM_J = 3'd5
   } imm_type_e;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;

   // True when v is representable as a w-bit two's-complement value.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
      logic [31:0] mask;
      mask = 32'hFFFF_FFFF << (w - 1);
      return ((v & mask) == 32'h0) || ((v & mask) == mask);
   endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational RV32I field packer; flags illegal format codes and, when
// INST_ENC_RANGE_CHECK_EN is defined, immediates that do not fit their format.
module inst_pack
   import inst_encoder_pkg::*;
(
   input  logic [6:0]  op_i,
   input  logic [2:0]  fn3_i,
   input  logic [6:0]  fn7_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   input  logic [2:0]  imm_type_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

`ifdef INST_ENC_RANGE_CHECK_EN
   logic range_ok;
`endif

   always_comb begin
      word_o    = 32'h0;
      illegal_o = 1'b0;
      case (imm_type_i)
         IMM_R: word_o = {fn7_i, rs2_i, rs1_i, fn3_i, rd_i, op_i};
         IMM_I: word_o = {imm_i[11:0], rs1_i, fn3_i, rd_i, op_i};
         IMM_S: word_o = {imm_i[11:5], rs2_i, rs1_i, fn3_i, imm_i[4:0], op_i};
         IMM_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, fn3_i,
                          imm_i[4:1], imm_i[11], op_i};
         IMM_U: word_o = {imm_i[31:12], rd_i, op_i};
         IMM_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
         default: illegal_o = 1'b1;
      endcase

`ifdef INST_ENC_RANGE_CHECK_EN
      range_ok = 1'b1;
      case (imm_type_i)
         IMM_I, IMM_S: range_ok = fits_signed(imm_i, 12);
         IMM_B:        range_ok = fits_signed(imm_i, 13) && !imm_i[0];
         IMM_J:        range_ok = fits_signed(imm_i, 21) && !imm_i[0];
         IMM_U:        range_ok = (imm_i[11:0] == 12'h0);
         default:      range_ok = 1'b1;
      endcase
      if (!range_ok) illegal_o = 1'b1;
`endif
   end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder and sequential instruction-memory writer with a single
// output register stage (S1). Optional immediate range check: INST_ENC_RANGE_CHECK_EN.
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        in_op,
   input  logic [2:0]        in_fn3,
   input  logic [6:0]        in_fn7,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   input  logic [2:0]        in_imm_type,
   input  logic              base_load,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              mem_ready,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              err,
   output logic              err_sticky
);

   logic              s1_valid_q, s1_valid_d;
   logic [31:0]       s1_word_q, s1_word_d;
   logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              sticky_q, sticky_d;

   logic [31:0]       pack_word;
   logic              pack_illegal;
   logic              accept, complete;
   logic [ADDR_W-1:0] base_ptr, cur_ptr;
   logic [1:0]        unused_base_bits;

   inst_pack u_pack (
      .op_i       (in_op),
      .fn3_i      (in_fn3),
      .fn7_i      (in_fn7),
      .rd_i       (in_rd),
      .rs1_i      (in_rs1),
      .rs2_i      (in_rs2),
      .imm_i      (in_imm),
      .imm_type_i (in_imm_type),
      .word_o     (pack_word),
      .illegal_o  (pack_illegal)
   );

   assign in_ready         = !s1_valid_q || mem_ready;
   assign accept           = in_valid && in_ready;
   assign complete         = s1_valid_q && mem_ready;
   assign base_ptr         = {base_addr[ADDR_W-1:2], 2'b00};
   assign unused_base_bits = base_addr[1:0];
   // A same-cycle base_load redirects the descriptor being accepted now.
   assign cur_ptr          = base_load ? base_ptr : ptr_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_word_d  = s1_word_q;
      s1_addr_d  = s1_addr_q;
      ptr_d      = cur_ptr;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      sticky_d   = sticky_q;
      if (complete) begin
         s1_valid_d = 1'b0;
         if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
      if (accept) begin
         if (pack_illegal) begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
         end else begin
            s1_valid_d = 1'b1;
            s1_word_d  = pack_word;
            s1_addr_d  = cur_ptr;
            ptr_d      = cur_ptr + ADDR_W'(4);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_word_q  <= 32'h0;
         s1_addr_q  <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_word_q  <= s1_word_d;
         s1_addr_q  <= s1_addr_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         sticky_q   <= sticky_d;
      end
   end

   assign mem_we     = s1_valid_q ? 4'b1111 : 4'b0000;
   assign mem_addr   = s1_addr_q;
   assign mem_wdata  = s1_word_q;
   assign word_cnt   = cnt_q;
   assign err        = err_q;
   assign err_sticky = sticky_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed program steps followed by
// randomized descriptors checked against a behavioural encoder/writer model.
module tb_inst_encoder;
   import inst_encoder_pkg::*;

   localparam int ADDR_W = 12;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [6:0]        in_op = '0;
   logic [2:0]        in_fn3 = '0;
   logic [6:0]        in_fn7 = '0;
   logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0]       in_imm = '0;
   logic [2:0]        in_imm_type = '0;
   logic              base_load = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              mem_ready;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [CNT_W-1:0]  word_cnt;
   logic              err, err_sticky;

   logic rand_rdy_en = 1'b0;
   logic mr_fixed = 1'b1;
   logic mr_rand = 1'b1;
   assign mem_ready = rand_rdy_en ? mr_rand : mr_fixed;

   inst_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_fn3(in_fn3), .in_fn7(in_fn7), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_imm_type(in_imm_type),
      .base_load(base_load), .base_addr(base_addr), .mem_ready(mem_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .word_cnt(word_cnt), .err(err), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 mr_rand = ($urandom_range(0, 3) != 0);
   end

   typedef struct {
      int unsigned addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          total = 0;
   int          bad = 0;
   int unsigned model_ptr = 0;
   int          writes_seen = 0;
   int          cnt_base = 0;

   function automatic int unsigned fld(input int unsigned v, input int hi, input int lo);
      return (v >> lo) % (1 << (hi - lo + 1));
   endfunction

   // Word layout written out from the format tables as field * 2^position.
   function automatic logic [31:0] ref_encode(input int unsigned op, fn3, fn7, rd,
                                              rs1, rs2, imm, input int t);
      int unsigned w;
      case (t)
         0: w = op + rd*(1<<7) + fn3*(1<<12) + rs1*(1<<15) + rs2*(1<<20) + fn7*(1<<25);
         1: w = op + rd*(1<<7) + fn3*(1<<12) + rs1*(1<<15) + fld(imm,11,0)*(1<<20);
         2: w = op + fld(imm,4,0)*(1<<7) + fn3*(1<<12) + rs1*(1<<15) + rs2*(1<<20)
                + fld(imm,11,5)*(1<<25);
         3: w = op + fld(imm,11,11)*(1<<7) + fld(imm,4,1)*(1<<8) + fn3*(1<<12)
                + rs1*(1<<15) + rs2*(1<<20) + fld(imm,10,5)*(1<<25)
                + fld(imm,12,12)*(1<<31);
         4: w = op + rd*(1<<7) + fld(imm,31,12)*(1<<12);
         5: w = op + rd*(1<<7) + fld(imm,19,12)*(1<<12) + fld(imm,11,11)*(1<<20)
                + fld(imm,10,1)*(1<<21) + fld(imm,20,20)*(1<<31);
         default: w = 0;
      endcase
      return w;
   endfunction

   function automatic bit ref_illegal(input logic [31:0] imm, input int t);
      int s;
      s = signed'(imm);
      if (t > 5) return 1'b1;
`ifdef INST_ENC_RANGE_CHECK_EN
      case (t)
         1, 2: return (s < -2048) || (s > 2047);
         3:    return (s < -4096) || (s > 4094) || (s % 2 != 0);
         4:    return (imm % 4096) != 0;
         5:    return (s < -(1 << 20)) || (s > (1 << 20) - 2) || (s % 2 != 0);
         default: return 1'b0;
      endcase
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Called at a negative edge: a write completes at the next rising edge.
   task automatic check_write();
      wr_t e;
      if (rst_n === 1'b1 && mem_we !== 4'h0 && mem_ready === 1'b1) begin
         writes_seen++;
         check("mem_we_full", {60'h0, mem_we}, 64'hF);
         check("write_expected", {63'h0, (exp_q.size() > 0)}, 64'h1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("write_addr", {52'h0, mem_addr}, {32'h0, e.addr});
            check("write_data", {32'h0, mem_wdata}, {32'h0, e.data});
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         check_write();
         @(posedge clk);
         #1;
      end
   endtask

   // Entered and left just after a rising edge.
   task automatic send(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm, input logic [2:0] t,
                       input bit bl, input int unsigned ba,
                       input bit use_exp, input logic [31:0] exp_w);
      bit          accepted;
      bit          ill;
      int          n;
      int unsigned a;
      wr_t         e;
      in_op = op; in_fn3 = fn3; in_fn7 = fn7; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_imm = imm; in_imm_type = t; base_load = bl; base_addr = ADDR_W'(ba);
      in_valid = 1'b1;
      accepted = 1'b0;
      ill = ref_illegal(imm, int'(t));
      n = 0;
      while (!accepted && n < 100) begin
         @(negedge clk);
         check_write();
         if (in_ready === 1'b1) begin
            accepted = 1'b1;
            a = bl ? (ba & 32'hFFC) : model_ptr;
            if (ill) begin
               model_ptr = a;
            end else begin
               e.addr = a;
               e.data = use_exp ? exp_w
                        : ref_encode(op, fn3, fn7, rd, rs1, rs2, imm, int'(t));
               exp_q.push_back(e);
               model_ptr = (a + 4) % (1 << ADDR_W);
            end
         end
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      base_load = 1'b0;
      total++;
      assert (accepted) else begin
         bad++;
         $error("FAIL accept_timeout observed=%0d cycles expected=accept", n);
      end
      if (accepted) begin
         check("err_pulse", {63'h0, err}, {63'h0, ill});
         if (ill) check("err_sticky_set", {63'h0, err_sticky}, 64'h1);
      end
   endtask

   initial begin
      logic [31:0] imm;
      int          t;
      bit          expect_range_err;
`ifdef INST_ENC_RANGE_CHECK_EN
      expect_range_err = 1'b1;
`else
      expect_range_err = 1'b0;
`endif

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {63'h0, in_ready}, 64'h1);
      check("rst_mem_we", {60'h0, mem_we}, 64'h0);
      check("rst_mem_addr", {52'h0, mem_addr}, 64'h0);
      check("rst_mem_wdata", {32'h0, mem_wdata}, 64'h0);
      check("rst_word_cnt", {48'h0, word_cnt}, 64'h0);
      check("rst_err", {63'h0, err}, 64'h0);
      check("rst_err_sticky", {63'h0, err_sticky}, 64'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Test 1: back-to-back I/S/B
      send(OP_IMM,    3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,        IMM_I, 0, 0, 1, 32'h00500093);
      send(OP_STORE,  3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,        IMM_S, 0, 0, 1, 32'h0020A423);
      send(OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, IMM_B, 0, 0, 1, 32'hFE000EE3);
      check("t1_throughput_pending", {32'h0, 32'(exp_q.size())}, 64'd1);
      idle(2);
      check("t1_word_cnt", {48'h0, word_cnt}, 64'd3);

      // Test 2: J and U
      send(OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048,      IMM_J, 0, 0, 1, 32'h001000EF);
      send(OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, IMM_U, 0, 0, 1, 32'h123452B7);
      idle(2);
      check("t2_word_cnt", {48'h0, word_cnt}, 64'd5);

      // Test 3: backpressure holds S1
      mr_fixed = 1'b0;
      send(OP_IMM, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd7, IMM_I, 0, 0, 1, 32'h00700193);
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_write();
         check("t3_in_ready_low", {63'h0, in_ready}, 64'h0);
         check("t3_mem_we_hold", {60'h0, mem_we}, 64'hF);
         check("t3_addr_hold", {52'h0, mem_addr}, 64'h014);
         check("t3_data_hold", {32'h0, mem_wdata}, 64'h00700193);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mr_fixed = 1'b1;
      idle(3);
      check("t3_word_cnt", {48'h0, word_cnt}, 64'd6);
      check("t3_drained", {32'h0, 32'(exp_q.size())}, 64'd0);

      // Test 4: base load with accept, then wrap
      send(OP_IMM, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd1, IMM_I, 1, 32'hFFE, 0, 32'h0);
      check("t4_base_addr", {52'h0, mem_addr}, 64'hFFC);
      send(OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd2, IMM_I, 0, 0, 0, 32'h0);
      check("t4_wrap_addr", {52'h0, mem_addr}, 64'h000);
      idle(2);

      // Test 5: out-of-range I immediate
      if (expect_range_err)
         send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, IMM_I, 0, 0, 0, 32'h0);
      else
         send(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, IMM_I, 0, 0, 1, 32'h00000093);
      check("t5_err_sticky", {63'h0, err_sticky}, {63'h0, expect_range_err});
      send(OP_IMM, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'd1, IMM_I, 0, 0, 0, 32'h0);
      check("t5_next_addr", {52'h0, mem_addr}, expect_range_err ? 64'h004 : 64'h008);
      idle(2);

      // Test 6: illegal format code, then reset with S1 full
      send(OP_IMM, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'd3, 3'd7, 0, 0, 0, 32'h0);
      check("t6_err_sticky", {63'h0, err_sticky}, 64'h1);
      idle(1);
      check("t6_err_one_cycle", {63'h0, err}, 64'h0);
      mr_fixed = 1'b0;
      send(OP_IMM, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'd9, IMM_I, 0, 0, 0, 32'h0);
      check("t6_s1_full", {60'h0, mem_we}, 64'hF);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_mem_we", {60'h0, mem_we}, 64'h0);
      check("t6_rst_in_ready", {63'h0, in_ready}, 64'h1);
      check("t6_rst_addr", {52'h0, mem_addr}, 64'h0);
      check("t6_rst_wdata", {32'h0, mem_wdata}, 64'h0);
      check("t6_rst_cnt", {48'h0, word_cnt}, 64'h0);
      check("t6_rst_err_sticky", {63'h0, err_sticky}, 64'h0);
      exp_q.delete();
      model_ptr = 0;
      cnt_base = writes_seen;
      mr_fixed = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(OP_IMM, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'd4, IMM_I, 0, 0, 0, 32'h0);
      check("t6_post_rst_addr", {52'h0, mem_addr}, 64'h000);
      idle(2);
      check("t6_post_rst_cnt", {48'h0, word_cnt}, 64'd1);

      // Randomized descriptors with random backpressure
      rand_rdy_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
            1: imm = $urandom;
            2: imm = $urandom & 32'hFFFFF000;
            default: imm = 32'($urandom_range(0, 1 << 22)) - 32'(1 << 21);
         endcase
         if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
         t = $urandom_range(0, 7);
         send(7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), imm, 3'(t), ($urandom_range(0, 15) == 0),
              $urandom_range(0, 4095), 0, 32'h0);
         if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end
      rand_rdy_en = 1'b0;
      mr_fixed = 1'b1;
      idle(3);
      check("rand_drained", {32'h0, 32'(exp_q.size())}, 64'd0);
      check("rand_word_cnt", {48'h0, word_cnt}, 64'(writes_seen - cnt_base));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
